// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and default widths for the multi-channel PWM
//               generator. Holds the counting-mode and direction enums and
//               the default parameter values used by pwm_multi_gen and
//               pwm_channel.
// Config      : PWM_DEADTIME_EN (used by the modules that import this package)
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    localparam int c_DEF_CHANNELS = 4;
    localparam int c_DEF_CNT_W    = 8;
    localparam int c_DEF_PRESC_W  = 8;
    localparam int c_DEF_DEAD_CYC = 2;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_channel
// Description : One PWM compare channel. Double-buffered duty (shadow written
//               by the config path, active loaded at period boundaries) and a
//               registered compare against the shared counter.
//               With PWM_DEADTIME_EN defined the raw compare drives a
//               dead-time FSM producing a non-overlapping complementary pair.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               run           - counter running (compare enabled)
//               load          - period boundary: shadow -> active duty
//               wr_en/wr_duty - shadow duty write
//               cnt           - shared period counter
//               pwm_out       - registered PWM output
//               pwm_n_out     - complementary output (PWM_DEADTIME_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = c_DEF_CNT_W
`ifdef PWM_DEADTIME_EN
    , parameter int DEAD_CYC = c_DEF_DEAD_CYC
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_duty,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm_out
`ifdef PWM_DEADTIME_EN
    , output logic           pwm_n_out
`endif
);

    logic [CNT_W-1:0] r_duty_sh;
    logic [CNT_W-1:0] r_duty_act;
    logic             r_raw;

    // The active duty only changes at a boundary, so the compare can never
    // produce a runt pulse from a mid-period duty write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_sh  <= '0;
            r_duty_act <= '0;
            r_raw      <= 1'b0;
        end else begin
            if (wr_en) begin
                r_duty_sh <= wr_duty;
            end
            if (load) begin
                r_duty_act <= r_duty_sh;
            end
            r_raw <= run && (cnt < r_duty_act);
        end
    end

`ifdef PWM_DEADTIME_EN
    localparam logic [1:0] c_ST_IDLE_LO = 2'd0;
    localparam logic [1:0] c_ST_DT_RISE = 2'd1;
    localparam logic [1:0] c_ST_HI      = 2'd2;
    localparam logic [1:0] c_ST_DT_FALL = 2'd3;
    localparam int         c_DT_W       = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [c_DT_W-1:0] c_DT_LAST = c_DT_W'(DEAD_CYC - 1);

    logic [1:0]        r_state;
    logic [c_DT_W-1:0] r_dt_cnt;
    logic              r_run_d;

    // Both sides stay low for DEAD_CYC clocks around every raw edge. A raw
    // pulse that ends inside the gap is swallowed on that side.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE_LO;
            r_dt_cnt <= '0;
            r_run_d  <= 1'b0;
        end else begin
            r_run_d <= run;
            case (r_state)
                c_ST_IDLE_LO: begin
                    if (r_raw) begin
                        r_state  <= c_ST_DT_RISE;
                        r_dt_cnt <= '0;
                    end
                end
                c_ST_DT_RISE: begin
                    if (!r_raw) begin
                        r_state <= c_ST_IDLE_LO;
                    end else if (r_dt_cnt == c_DT_LAST) begin
                        r_state <= c_ST_HI;
                    end else begin
                        r_dt_cnt <= r_dt_cnt + 1'b1;
                    end
                end
                c_ST_HI: begin
                    if (!r_raw) begin
                        r_state  <= c_ST_DT_FALL;
                        r_dt_cnt <= '0;
                    end
                end
                default: begin
                    if (r_raw) begin
                        r_state <= c_ST_HI;
                    end else if (r_dt_cnt == c_DT_LAST) begin
                        r_state <= c_ST_IDLE_LO;
                    end else begin
                        r_dt_cnt <= r_dt_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign pwm_out   = (r_state == c_ST_HI);
    assign pwm_n_out = (r_state == c_ST_IDLE_LO) && r_run_d;
`else
    assign pwm_out = r_raw;
`endif

endmodule : pwm_channel
`default_nettype wire

// File: rtl/pwm_multi_gen.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_gen
// Description : Multi-channel PWM generator. One shared prescaler and period
//               counter (edge- or centre-aligned), CHANNELS compare channels
//               with double-buffered duties applied at period boundaries.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               en           - run enable (0->1 forces a boundary)
//               presc        - tick every presc+1 clocks
//               period       - counter top value (latched at boundary)
//               mode         - 0 edge-aligned, 1 centre-aligned (latched)
//               cfg_valid/cfg_ready/cfg_ch/cfg_duty - duty write handshake
//               pwm_out      - registered PWM outputs
//               pwm_n_out    - complementary outputs (PWM_DEADTIME_EN only)
//               period_tick  - one-clock pulse in each boundary clock
// Config      : PWM_DEADTIME_EN - adds pwm_n_out and dead-time insertion
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int CHANNELS = c_DEF_CHANNELS,
    parameter int CNT_W    = c_DEF_CNT_W,
    parameter int PRESC_W  = c_DEF_PRESC_W,
    parameter int DEAD_CYC = c_DEF_DEAD_CYC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PRESC_W-1:0]  presc,
    input  logic [CNT_W-1:0]    period,
    input  logic                mode,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]    cfg_duty,
    output logic [CHANNELS-1:0] pwm_out,
`ifdef PWM_DEADTIME_EN
    output logic [CHANNELS-1:0] pwm_n_out,
`endif
    output logic                period_tick
);

    if (CHANNELS < 1 || CHANNELS > 8 || DEAD_CYC < 1) begin : g_param_check
        $error("pwm_multi_gen: CHANNELS must be 1..8 and DEAD_CYC >= 1");
    end

    logic [PRESC_W-1:0] r_p_cnt;
    logic [CNT_W-1:0]   r_cnt;
    pwm_dir_e           r_dir;
    logic [CNT_W-1:0]   r_period_act;
    pwm_mode_e          r_mode_act;
    logic               r_en_d;

    logic               w_tick;
    logic               w_wrap;
    logic [CNT_W-1:0]   w_cnt_next;
    pwm_dir_e           w_dir_next;
    logic               w_boundary;
    logic               w_run;
    logic               w_wr_acc;

    assign w_tick = en && (r_p_cnt == presc);

    // Next counter value on a tick. w_wrap marks the tick that closes the
    // period. Centre mode walks 0..P..1 so a full period is 2*P ticks and
    // the down-count's arrival at 0 is the restart point.
    always_comb begin
        w_cnt_next = r_cnt;
        w_dir_next = r_dir;
        w_wrap     = 1'b0;
        if (r_mode_act == PWM_EDGE) begin
            if (r_cnt == r_period_act) begin
                w_wrap = 1'b1;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end else if (r_period_act == '0) begin
            w_wrap = 1'b1;
        end else if (r_dir == DIR_UP && r_cnt != r_period_act) begin
            w_cnt_next = r_cnt + 1'b1;
        end else begin
            w_dir_next = DIR_DOWN;
            w_cnt_next = r_cnt - 1'b1;
            w_wrap     = (r_cnt == CNT_W'(1));
        end
    end

    // Rising en forces a boundary so fresh shadows take effect immediately.
    assign w_boundary  = en && (!r_en_d || (w_tick && w_wrap));
    assign period_tick = !rst && w_boundary;
    assign cfg_ready   = rst || !w_boundary;
    assign w_run       = en && r_en_d;
    assign w_wr_acc    = cfg_valid && cfg_ready && !rst && (int'(cfg_ch) < CHANNELS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_cnt      <= '0;
            r_cnt        <= '0;
            r_dir        <= DIR_UP;
            r_period_act <= '0;
            r_mode_act   <= PWM_EDGE;
            r_en_d       <= 1'b0;
        end else begin
            r_en_d <= en;
            if (!en) begin
                r_p_cnt <= '0;
                r_cnt   <= '0;
                r_dir   <= DIR_UP;
            end else if (w_boundary) begin
                r_p_cnt      <= '0;
                r_cnt        <= '0;
                r_dir        <= DIR_UP;
                r_period_act <= period;
                r_mode_act   <= pwm_mode_e'(mode);
            end else if (w_tick) begin
                r_p_cnt <= '0;
                r_cnt   <= w_cnt_next;
                r_dir   <= w_dir_next;
            end else begin
                r_p_cnt <= r_p_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .CNT_W    (CNT_W)
`ifdef PWM_DEADTIME_EN
            , .DEAD_CYC (DEAD_CYC)
`endif
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .run       (w_run),
            .load      (w_boundary),
            .wr_en     (w_wr_acc && (int'(cfg_ch) == i)),
            .wr_duty   (cfg_duty),
            .cnt       (r_cnt),
            .pwm_out   (pwm_out[i])
`ifdef PWM_DEADTIME_EN
            , .pwm_n_out (pwm_n_out[i])
`endif
        );
    end

endmodule : pwm_multi_gen
`default_nettype wire
